// File: rtl/pipe_msg_fifo.sv
// Elastic in-order buffer for 96-bit portal pipe messages between an enq producer and consumer.
// Optional zero-latency pass-through when empty: define PIPE_MSG_FIFO_BYPASS_EN.
module pipe_msg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  input  logic                   out_enq__RDY,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic             overflow_q;

  logic empty;
  logic full;
  logic bypass;
  logic do_enq;
  logic do_deq;

  always_comb begin
    empty  = (cnt == '0);
    full   = (cnt == FULL_CNT);
`ifdef PIPE_MSG_FIFO_BYPASS_EN
    bypass = empty & in_enq__ENA & out_enq__RDY;
`else
    bypass = 1'b0;
`endif
    // A bypassed message is consumed directly and never touches storage.
    do_enq = in_enq__ENA & ~full & ~bypass;
    do_deq = ~empty & out_enq__RDY;
  end

  assign in_enq__RDY  = ~full;
  assign out_enq__ENA = do_deq | bypass;
  assign out_enq_v    = bypass ? in_enq_v : mem[rp];
  assign count        = cnt;
  assign overflow     = overflow_q;

  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem[wp] <= in_enq_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rp         <= '0;
      wp         <= '0;
      cnt        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_enq) begin
        wp <= wp + 1'b1;
      end
      if (do_deq) begin
        rp <= rp + 1'b1;
      end
      if (do_enq && !do_deq) begin
        cnt <= cnt + 1'b1;
      end else if (!do_enq && do_deq) begin
        cnt <= cnt - 1'b1;
      end
      if (in_enq__ENA && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
